// File: rtl/fft_input_buffer.sv
// Frame buffer in front of the first FFT stage: fills N samples, then serves one per request.
// Build option FFT_IN_BITREV_EN: serve in bit-reversed index order (otherwise natural order).
module fft_input_buffer #(
    parameter int Q     = 15,
    parameter int N     = 8,
    parameter int LOG2N = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic signed [Q:0]   sample_in,
    input  logic                valid_request,
    output logic                valid_packet,
    output logic                valid_out,
    output logic signed [Q:0]   data_out_real,
    output logic [3:0]          addr_out,
    output logic                frame_done,
    output logic                overflow,
    output logic                req_error
);

    typedef enum logic {FILL, SERVE} state_t;

    state_t             state, state_nxt;
    logic [LOG2N-1:0]   wr_ptr, rd_cnt, rd_idx;
    logic signed [Q:0]  buffer [N];
    logic               do_write, do_serve, last_write, last_serve;

`ifdef FFT_IN_BITREV_EN
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] i);
        logic [LOG2N-1:0] r;
        for (int k = 0; k < LOG2N; k++) r[k] = i[LOG2N-1-k];
        return r;
    endfunction

    always_comb rd_idx = bitrev(rd_cnt);
`else
    always_comb rd_idx = rd_cnt;
`endif

    always_comb begin
        state_nxt  = state;
        do_write   = 1'b0;
        do_serve   = 1'b0;
        last_write = 1'b0;
        last_serve = 1'b0;
        case (state)
            FILL: begin
                do_write   = sample_valid;
                last_write = sample_valid && (wr_ptr == LOG2N'(N-1));
                if (last_write) state_nxt = SERVE;
            end
            SERVE: begin
                do_serve   = valid_request;
                last_serve = valid_request && (rd_cnt == LOG2N'(N-1));
                if (last_serve) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Buffer has no reset: stale contents are never read before a full refill.
    always_ff @(posedge clk) begin
        if (do_write) buffer[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FILL;
            wr_ptr        <= '0;
            rd_cnt        <= '0;
            valid_packet  <= 1'b0;
            valid_out     <= 1'b0;
            data_out_real <= '0;
            addr_out      <= '0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            req_error     <= 1'b0;
        end else begin
            state        <= state_nxt;
            // Drops together with the last response, rises the cycle after the last write.
            valid_packet <= (state_nxt == SERVE);
            valid_out    <= do_serve;
            frame_done   <= last_serve;
            req_error    <= (state == FILL) && valid_request;
            overflow     <= overflow | ((state == SERVE) && sample_valid);
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_serve) begin
                rd_cnt        <= rd_cnt + 1'b1;
                data_out_real <= buffer[rd_idx];
                addr_out      <= 4'(rd_idx);
            end
        end
    end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Scoreboard bench for fft_input_buffer (N=8); expected order follows the FFT_IN_BITREV_EN build.
module tb_fft_input_buffer;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_valid = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic               valid_request = 1'b0;
    logic               valid_packet, valid_out, frame_done, overflow, req_error;
    logic signed [15:0] data_out_real;
    logic [3:0]         addr_out;

    fft_input_buffer #(.Q(15), .N(8), .LOG2N(3)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .valid_request(valid_request), .valid_packet(valid_packet), .valid_out(valid_out),
        .data_out_real(data_out_real), .addr_out(addr_out), .frame_done(frame_done),
        .overflow(overflow), .req_error(req_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] data;
        logic [3:0]         addr;
        logic               last;
    } exp_t;

    exp_t               exp_q[$];
    exp_t               mon_e;
    int                 n_vec = 0;
    int                 n_err = 0;
    bit                 mdl_serve = 0;
    int                 mdl_rd = 0;
    int                 mdl_wr = 0;
    logic signed [15:0] mdl_buf [8];
    logic signed [15:0] last_data = '0;
    int                 br_lut [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic int ridx(input int i);
`ifdef FFT_IN_BITREV_EN
        return br_lut[i];
`else
        return i;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus and advance the reference model.
    task automatic drive(input logic sv, input logic signed [15:0] si, input logic req);
        exp_t e;
        int   id;
        bit   s0;
        s0 = mdl_serve;
        sample_valid  = sv;
        sample_in     = si;
        valid_request = req;
        if (s0 && req) begin
            id     = ridx(mdl_rd);
            e.data = mdl_buf[id];
            e.addr = 4'(id);
            e.last = (mdl_rd == 7);
            exp_q.push_back(e);
            last_data = e.data;
            if (mdl_rd == 7) mdl_serve = 0;
            mdl_rd = (mdl_rd + 1) % 8;
        end
        if (!s0 && sv) begin
            mdl_buf[mdl_wr] = si;
            if (mdl_wr == 7) mdl_serve = 1;
            mdl_wr = (mdl_wr + 1) % 8;
        end
        step();
        sample_valid  = 1'b0;
        valid_request = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
        mdl_serve = 0;
        mdl_rd    = 0;
        mdl_wr    = 0;
        exp_q.delete();
    endtask

    task automatic fill(input int base, input int inc);
        for (int i = 0; i < 8; i++) drive(1'b1, 16'(base + inc * i), 1'b0);
    endtask

    // Every response is popped from the scoreboard and compared here.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid_out: got data %0d addr %0d, expected no response",
                         data_out_real, addr_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_out_real !== mon_e.data || addr_out !== mon_e.addr ||
                    frame_done !== mon_e.last) begin
                    n_err++;
                    $display("FAIL response: got data %0d addr %0d done %b, expected data %0d addr %0d done %b",
                             data_out_real, addr_out, frame_done, mon_e.data, mon_e.addr, mon_e.last);
                end
            end
        end else if (frame_done !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_done_alone: got %b, expected 0 without valid_out", frame_done);
        end
    end

    task automatic test_reset();
        apply_reset(2);
        n_vec++;
        if ({valid_packet, valid_out, frame_done, overflow, req_error} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {valid_packet, valid_out, frame_done, overflow, req_error});
        end
        n_vec++;
        if (data_out_real !== 16'sd0 || addr_out !== 4'd0) begin
            n_err++;
            $display("FAIL reset_data: got data %0d addr %0d, expected 0 0", data_out_real, addr_out);
        end
    endtask

    task automatic test_basic_frame();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(10 + i), 1'b0);
            if (i >= 6) begin
                n_vec++;
                if (valid_packet !== (i == 7)) begin
                    n_err++;
                    $display("FAIL valid_packet_w%0d: got %b, expected %b", i, valid_packet, i == 7);
                end
            end
        end
    endtask

    task automatic test_spaced_serve();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 16'sd0, 1'b1);
            step();
            n_vec++;
            if (valid_out !== 1'b0 || data_out_real !== last_data) begin
                n_err++;
                $display("FAIL gap_hold_%0d: got vo %b data %0d, expected vo 0 data %0d",
                         k, valid_out, data_out_real, last_data);
            end
            step();
        end
        n_vec++;
        if (valid_packet !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL spaced_end: got valid_packet %b pending %0d, expected 0 0",
                     valid_packet, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        fill(20, 1);
        for (int k = 0; k < 8; k++) drive(1'b0, 16'sd0, 1'b1);
        step();
        n_vec++;
        if (valid_out !== 1'b0 || valid_packet !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_end: got vo %b vp %b pending %0d, expected 0 0 0",
                     valid_out, valid_packet, exp_q.size());
        end
        fill(-3, -1);
        n_vec++;
        if (valid_packet !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_refill: got valid_packet %b, expected 1", valid_packet);
        end
        for (int k = 0; k < 8; k++) drive(1'b0, 16'sd0, 1'b1);
        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_negative: got pending %0d, expected 0", exp_q.size());
        end
    endtask

    task automatic test_errors();
        drive(1'b0, 16'sd0, 1'b1);
        n_vec++;
        if (req_error !== 1'b1 || valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL req_in_fill: got req_error %b vo %b, expected 1 0", req_error, valid_out);
        end
        step();
        n_vec++;
        if (req_error !== 1'b0) begin
            n_err++;
            $display("FAIL req_error_pulse: got %b, expected 0", req_error);
        end
        drive(1'b1, 16'sd30, 1'b1);
        n_vec++;
        if (req_error !== 1'b1) begin
            n_err++;
            $display("FAIL req_with_sample: got req_error %b, expected 1", req_error);
        end
        for (int i = 1; i < 8; i++) drive(1'b1, 16'(30 + i), 1'b0);
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_early: got %b, expected 0", overflow);
        end
        drive(1'b1, 16'sd99, 1'b0);
        n_vec++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_set: got %b, expected 1", overflow);
        end
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 16'sd0, 1'b1);
            step();
        end
        drive(1'b1, 16'sd99, 1'b1);
        repeat (3) step();
        n_vec++;
        if (overflow !== 1'b1 || valid_packet !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL overflow_sticky: got ovf %b vp %b pending %0d, expected 1 0 0",
                     overflow, valid_packet, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_serve();
        fill(40, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 16'sd0, 1'b1);
            step();
        end
        reset = 1'b1;
        step();
        n_vec++;
        if ({valid_packet, valid_out, frame_done, overflow, req_error} !== 5'b0 ||
            data_out_real !== 16'sd0 || addr_out !== 4'd0) begin
            n_err++;
            $display("FAIL mid_reset: got flags %b data %0d addr %0d, expected 00000 0 0",
                     {valid_packet, valid_out, frame_done, overflow, req_error}, data_out_real, addr_out);
        end
        apply_reset(0);
        fill(0, 1);
        drive(1'b0, 16'sd0, 1'b1);
        step();
        n_vec++;
        if (exp_q.size() != 0 || valid_packet !== 1'b1) begin
            n_err++;
            $display("FAIL after_reset_serve: got pending %0d vp %b, expected 0 1",
                     exp_q.size(), valid_packet);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_spaced_serve();
        test_back_to_back();
        test_errors();
        test_reset_mid_serve();
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
